// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NREQ byte requesters.
// Requests are picked round-robin, then each frame goes LAUNCH -> WAIT_START
// -> WAIT_END -> DONE. A watchdog in WAIT_START abandons a frame whose
// transmitter never raises Busy. Every output comes straight from a register.
module uart_tx_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_par_en,
   input  logic [NREQ-1:0]       req_par_typ,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_EN,
   output logic                  PAR_TYP,
   input  logic                  Busy,
   output logic                  active,
   output logic                  timeout_err,
   input  logic                  clear_err
);

   // Index width is kept at least 1 so NREQ=1 still has a legal pointer.
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_END,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   widx_q, widx_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              dv_q, dv_d;
   logic              parEn_q, parEn_d;
   logic              parTyp_q, parTyp_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              active_q, active_d;

   logic              found;
   logic [IDXW-1:0]   pick;
   logic [IDXW:0]     scan;
   logic [WIDTH-1:0]  selData;
   logic              selParEn;
   logic              selParTyp;

   // Round-robin pick: first asserted request at or above ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      scan  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, ptr_q} + (IDXW+1)'(k);
         if (scan >= (IDXW+1)'(NREQ)) begin
            scan = scan - (IDXW+1)'(NREQ);
         end
         if (!found && req[scan[IDXW-1:0]]) begin
            found = 1'b1;
            pick  = scan[IDXW-1:0];
         end
      end
   end

   // Mux the winner's byte and parity settings out of the flat request buses.
   always_comb begin
      selData   = '0;
      selParEn  = 1'b0;
      selParTyp = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IDXW'(i)) begin
            selData   = req_data[i*WIDTH +: WIDTH];
            selParEn  = req_par_en[i];
            selParTyp = req_par_typ[i];
         end
      end
   end

   // Frame sequencer next-state and registered-output next values.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      widx_d   = widx_q;
      grant_d  = grant_q;
      done_d   = '0;
      data_d   = data_q;
      dv_d     = 1'b0;
      parEn_d  = parEn_q;
      parTyp_d = parTyp_q;
      cnt_d    = cnt_q;
      err_d    = err_q;

      if (clear_err) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d  = LAUNCH;
               widx_d   = pick;
               grant_d  = NREQ'(1) << pick;
               data_d   = selData;
               parEn_d  = selParEn;
               parTyp_d = selParTyp;
               dv_d     = 1'b1;
            end
         end
         LAUNCH: begin
            state_d = WAIT_START;
            cnt_d   = '0;
         end
         WAIT_START: begin
            if (Busy) begin
               state_d = WAIT_END;
            end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
               state_d = DONE;
               done_d  = grant_q;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         WAIT_END: begin
            if (!Busy) begin
               state_d = DONE;
               done_d  = grant_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (widx_q == IDXW'(NREQ - 1)) ? '0 : widx_q + IDXW'(1);
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      active_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame without a done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         widx_q   <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         data_q   <= '0;
         dv_q     <= 1'b0;
         parEn_q  <= 1'b0;
         parTyp_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         widx_q   <= widx_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         data_q   <= data_d;
         dv_q     <= dv_d;
         parEn_q  <= parEn_d;
         parTyp_q <= parTyp_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         active_q <= active_d;
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign P_DATA      = data_q;
   assign DATA_VALID  = dv_q;
   assign PAR_EN      = parEn_q;
   assign PAR_TYP     = parTyp_q;
   assign active      = active_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (WIDTH=8, NREQ=4, TIMEOUT=16).
// The bench plays the uart_tx role by driving Busy by hand.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] reqData;
   logic [3:0]  reqParEn;
   logic [3:0]  reqParTyp;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [7:0]  pData;
   logic        dataValid;
   logic        parEn;
   logic        parTyp;
   logic        busy;
   logic        active;
   logic        timeoutErr;
   logic        clearErr;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.WIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (reqData),
      .req_par_en  (reqParEn),
      .req_par_typ (reqParTyp),
      .grant       (grant),
      .done        (done),
      .P_DATA      (pData),
      .DATA_VALID  (dataValid),
      .PAR_EN      (parEn),
      .PAR_TYP     (parTyp),
      .Busy        (busy),
      .active      (active),
      .timeout_err (timeoutErr),
      .clear_err   (clearErr)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete frame from IDLE with a pending request: launch, one Busy
   // cycle, done pulse, back to IDLE.
   task automatic runFrame(input logic [1:0] idx, input logic [7:0] expData,
                           input logic expParEn, input logic expParTyp);
      logic [3:0] oneHot;
      oneHot = 4'b0001 << idx;
      tick();
      checkOutput("launchGrant", 32'(grant), 32'(oneHot));
      checkOutput("launchDv", 32'(dataValid), 32'd1);
      checkOutput("launchData", 32'(pData), 32'(expData));
      checkOutput("launchParEn", 32'(parEn), 32'(expParEn));
      checkOutput("launchParTyp", 32'(parTyp), 32'(expParTyp));
      tick();
      checkOutput("waitStartDv", 32'(dataValid), 32'd0);
      checkOutput("waitStartActive", 32'(active), 32'd1);
      busy = 1'b1;
      tick();
      checkOutput("waitEndDone", 32'(done), 32'd0);
      busy = 1'b0;
      tick();
      checkOutput("doneBit", 32'(done), 32'(oneHot));
      checkOutput("doneGrant", 32'(grant), 32'(oneHot));
      tick();
      checkOutput("idleDone", 32'(done), 32'd0);
      checkOutput("idleGrant", 32'(grant), 32'd0);
      checkOutput("idleActive", 32'(active), 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      req       = 4'b0000;
      reqData   = 32'h0;
      reqParEn  = 4'b0000;
      reqParTyp = 4'b0000;
      busy      = 1'b0;
      clearErr  = 1'b0;

      // Reset values
      #2;
      checkOutput("rstGrant", 32'(grant), 32'd0);
      checkOutput("rstActive", 32'(active), 32'd0);
      checkOutput("rstDv", 32'(dataValid), 32'd0);
      checkOutput("rstErr", 32'(timeoutErr), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("idleAfterRst", 32'(active), 32'd0);

      // Single requester: index 2, byte A5, parity enabled even
      $display("[TB] single requester");
      reqData   = 32'h00A5_0000;
      reqParEn  = 4'b0100;
      reqParTyp = 4'b0000;
      req       = 4'b0100;
      runFrame(2'd2, 8'hA5, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      checkOutput("stayIdle", 32'(active), 32'd0);

      // Contention from a fresh reset: 1011 served 0,1,3,0,1,3
      $display("[TB] contention");
      rst = 1'b0;
      #1;
      rst = 1'b1;
      reqData   = 32'h4433_2211;
      reqParEn  = 4'b1010;
      reqParTyp = 4'b1000;
      req       = 4'b1011;
      runFrame(2'd0, 8'h11, 1'b0, 1'b0);
      runFrame(2'd1, 8'h22, 1'b1, 1'b0);
      runFrame(2'd3, 8'h44, 1'b1, 1'b1);
      runFrame(2'd0, 8'h11, 1'b0, 1'b0);
      runFrame(2'd1, 8'h22, 1'b1, 1'b0);
      runFrame(2'd3, 8'h44, 1'b1, 1'b1);

      // Pointer wrap: after index 3, 1001 serves 0 then 3
      $display("[TB] pointer wrap");
      req = 4'b1001;
      runFrame(2'd0, 8'h11, 1'b0, 1'b0);
      runFrame(2'd3, 8'h44, 1'b1, 1'b1);
      req = 4'b0000;

      // Dead transmitter on index 1, with clear_err racing the timeout
      $display("[TB] dead transmitter");
      req = 4'b0010;
      tick();
      checkOutput("deadLaunchGrant", 32'(grant), 32'b0010);
      checkOutput("deadLaunchDv", 32'(dataValid), 32'd1);
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
      end
      checkOutput("deadBeforeDone", 32'(done), 32'd0);
      checkOutput("deadBeforeErr", 32'(timeoutErr), 32'd0);
      checkOutput("deadBeforeActive", 32'(active), 32'd1);
      clearErr = 1'b1;
      tick();
      checkOutput("deadDone", 32'(done), 32'b0010);
      checkOutput("deadErrSetWins", 32'(timeoutErr), 32'd1);
      clearErr = 1'b0;
      req      = 4'b0100;
      tick();
      checkOutput("deadIdleErr", 32'(timeoutErr), 32'd1);
      checkOutput("deadIdleGrant", 32'(grant), 32'd0);
      clearErr = 1'b1;
      runFrame(2'd2, 8'h33, 1'b0, 1'b0);
      clearErr = 1'b0;
      checkOutput("errCleared", 32'(timeoutErr), 32'd0);
      req = 4'b0000;

      // Reset during WAIT_END, then pointer restarts at 0
      $display("[TB] reset mid-frame");
      req = 4'b1000;
      tick();
      tick();
      busy = 1'b1;
      tick();
      checkOutput("midActive", 32'(active), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midRstGrant", 32'(grant), 32'd0);
      checkOutput("midRstActive", 32'(active), 32'd0);
      checkOutput("midRstDone", 32'(done), 32'd0);
      checkOutput("midRstData", 32'(pData), 32'd0);
      checkOutput("midRstParEn", 32'(parEn), 32'd0);
      checkOutput("midRstParTyp", 32'(parTyp), 32'd0);
      busy = 1'b0;
      req  = 4'b1010;
      rst  = 1'b1;
      runFrame(2'd1, 8'h22, 1'b1, 1'b0);
      runFrame(2'd3, 8'h44, 1'b1, 1'b1);
      req = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
